// File: rtl/jleightcap_stack_core.sv
// jleightcap_stack_core
//   Four-entry, 8-bit stack machine that retires one 6-bit instruction per
//   clock edge. instr[5:4] selects the class and instr[3:0] is the field k.
//     00 PUSHLO  push {4'h0,k}
//     01 SETHI   top[7:4] <= k (pushes {k,4'h0} when the stack is empty)
//     10 ALU     ADD SUB AND OR XOR DUP DROP SWAP NOT SHL SHR [MUL] NOP
//     11 IO      OUT, CLR, STAT
//   Overflow (ovf) and underflow (unf) are sticky flags. Only CLR and reset
//   clear them.
//   Optional feature: define JLEIGHTCAP_MUL_EN to make ALU k=11 compute b*a.
//   If it is not defined, k=11 is a NOP and the build has no multiplier.
// Ports
//   clk     in   clock, rising-edge
//   rst     in   asynchronous reset, active-high
//   instr   in   [5:0] instruction, consumed on every rising edge
//   io_out  out  [7:0] registered output, updated only by OUT/STAT
module jleightcap_stack_core (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] instr,
   output logic [7:0] io_out
);

   localparam logic [1:0] C_PUSHLO = 2'b00;
   localparam logic [1:0] C_SETHI  = 2'b01;
   localparam logic [1:0] C_ALU    = 2'b10;
   localparam logic [1:0] C_IO     = 2'b11;

   // stk[0] is the top entry. Entries at or below depth are stale.
   logic [3:0][7:0] stk, stk_nx;
   logic [2:0]      depth, depth_nx;
   logic            ovf, ovf_nx, unf, unf_nx;
   logic [7:0]      io_nx;

   logic [1:0] cls;
   logic [3:0] k;
   logic       has1, has2, full, is_bin;
   logic [7:0] a, b, alu_r;

   assign cls  = instr[5:4];
   assign k    = instr[3:0];
   assign has1 = (depth != 3'd0);
   assign has2 = (depth >= 3'd2);
   assign full = (depth == 3'd4);
   // A missing operand reads as zero, so stale entries are never observable.
   assign a    = has1 ? stk[0] : 8'h00;
   assign b    = has2 ? stk[1] : 8'h00;

   always_comb begin
      alu_r  = 8'h00;
      is_bin = (k <= 4'd4);
`ifdef JLEIGHTCAP_MUL_EN
      if (k == 4'd11) is_bin = 1'b1;
`endif
      case (k)
         4'd0:    alu_r = b + a;
         4'd1:    alu_r = b - a;
         4'd2:    alu_r = b & a;
         4'd3:    alu_r = b | a;
         4'd4:    alu_r = b ^ a;
         4'd8:    alu_r = ~a;
         4'd9:    alu_r = {a[6:0], 1'b0};
         4'd10:   alu_r = {1'b0, a[7:1]};
`ifdef JLEIGHTCAP_MUL_EN
         4'd11:   alu_r = b * a;
`endif
         default: alu_r = 8'h00;
      endcase
   end

   always_comb begin
      stk_nx   = stk;
      depth_nx = depth;
      ovf_nx   = ovf;
      unf_nx   = unf;
      io_nx    = io_out;
      case (cls)
         C_PUSHLO: begin
            // A push at full depth shifts the bottom entry out.
            stk_nx   = {stk[2:0], {4'h0, k}};
            depth_nx = full ? depth : depth + 3'd1;
            ovf_nx   = ovf | full;
         end
         C_SETHI: begin
            if (has1) begin
               stk_nx[0][7:4] = k;
            end else begin
               stk_nx   = {stk[2:0], {k, 4'h0}};
               depth_nx = 3'd1;
            end
         end
         C_ALU: begin
            if (is_bin) begin
               // Pop two and push one. Depth never drops below 1.
               stk_nx   = {stk[3], stk[3], stk[2], alu_r};
               depth_nx = has2 ? depth - 3'd1 : 3'd1;
               unf_nx   = unf | ~has2;
            end else begin
               case (k)
                  4'd5: begin // DUP
                     stk_nx   = {stk[2:0], a};
                     depth_nx = full ? depth : depth + 3'd1;
                     ovf_nx   = ovf | full;
                     unf_nx   = unf | ~has1;
                  end
                  4'd6: begin // DROP
                     if (has1) begin
                        stk_nx   = {stk[3], stk[3:1]};
                        depth_nx = depth - 3'd1;
                     end else begin
                        unf_nx = 1'b1;
                     end
                  end
                  4'd7: begin // SWAP
                     stk_nx[0] = b;
                     stk_nx[1] = a;
                     unf_nx    = unf | ~has2;
                  end
                  4'd8, 4'd9, 4'd10: begin // unary ops modify the top in place
                     stk_nx[0] = alu_r;
                     unf_nx    = unf | ~has1;
                  end
                  default: ; // NOP
               endcase
            end
         end
         C_IO: begin
            case (k)
               4'd0: begin
                  io_nx  = a;
                  unf_nx = unf | ~has1;
               end
               4'd1: begin
                  depth_nx = 3'd0;
                  ovf_nx   = 1'b0;
                  unf_nx   = 1'b0;
               end
               4'd2:    io_nx = {ovf, unf, 3'b000, depth};
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stk    <= '0;
         depth  <= 3'd0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
         io_out <= 8'h00;
      end else begin
         stk    <= stk_nx;
         depth  <= depth_nx;
         ovf    <= ovf_nx;
         unf    <= unf_nx;
         io_out <= io_nx;
      end
   end

endmodule

// File: tb/tb_jleightcap_stack_core.sv
// Testbench for jleightcap_stack_core. Each OUT/STAT queues its expected
// value on a scoreboard when the instruction is driven. The value is popped
// and compared one edge later, when io_out has updated.
module tb_jleightcap_stack_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] instr = 6'h00;
   logic [7:0] io_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] sb [$];

   jleightcap_stack_core dut (
      .clk    (clk),
      .rst    (rst),
      .instr  (instr),
      .io_out (io_out)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] pl(input logic [3:0] k);  return {2'b00, k}; endfunction
   function automatic logic [5:0] sh(input logic [3:0] k);  return {2'b01, k}; endfunction
   function automatic logic [5:0] alu(input logic [3:0] k); return {2'b10, k}; endfunction
   localparam logic [5:0] OUT  = 6'b11_0000;
   localparam logic [5:0] CLR  = 6'b11_0001;
   localparam logic [5:0] STAT = 6'b11_0010;

   function automatic bit is_obs(input logic [5:0] i);
      return (i == OUT) || (i == STAT);
   endfunction

   // Apply one instruction for one rising edge. Return 1 ns after the edge.
   task automatic exec(input logic [5:0] i);
      instr = i;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [7:0] e;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (io_out !== 8'h00) begin n_bad++; $display("FAIL reset_init io_out=%h want 00", io_out); end
      rst = 1'b0;
      exec(pl(4'h5));
      sb.push_back(8'h05);
      exec(OUT);
      e = sb.pop_front();
      n_cmp++;
      if (io_out !== e) begin n_bad++; $display("FAIL reset_preout io_out=%h want %h", io_out, e); end
      exec(pl(4'h6));
      exec(pl(4'h7));
      // Assert reset between edges. The output must clear without a clock.
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if (io_out !== 8'h00) begin n_bad++; $display("FAIL reset_async io_out=%h want 00", io_out); end
      instr = OUT;
      @(posedge clk);
      #1;
      n_cmp++;
      if (io_out !== 8'h00) begin n_bad++; $display("FAIL reset_hold io_out=%h want 00", io_out); end
      #3 rst = 1'b0;
      sb.push_back(8'h00);
      exec(STAT);
      e = sb.pop_front();
      n_cmp++;
      if (io_out !== e) begin n_bad++; $display("FAIL reset_stat io_out=%h want %h", io_out, e); end
   endtask

   task automatic test_arith;
      logic [5:0] prog [$];
      logic [7:0] want [$];
      logic [7:0] e;
      prog = '{CLR, pl(4'h3), sh(4'h2), pl(4'h5), alu(4'd1), OUT, STAT};
      want = '{8'h1E, 8'h01};
      foreach (prog[i]) begin
         if (is_obs(prog[i])) sb.push_back(want.pop_front());
         exec(prog[i]);
         if (is_obs(prog[i])) begin
            e = sb.pop_front();
            n_cmp++;
            if (io_out !== e) begin n_bad++; $display("FAIL arith step %0d io_out=%h want %h", i, io_out, e); end
         end
      end
   endtask

   task automatic test_overflow;
      logic [5:0] prog [$];
      logic [7:0] want [$];
      logic [7:0] e;
      prog = '{CLR, pl(4'h1), pl(4'h2), pl(4'h3), pl(4'h4), pl(4'h5),
               alu(4'd6), alu(4'd6), alu(4'd6), OUT, STAT};
      want = '{8'h02, 8'h81};
      foreach (prog[i]) begin
         if (is_obs(prog[i])) sb.push_back(want.pop_front());
         exec(prog[i]);
         if (is_obs(prog[i])) begin
            e = sb.pop_front();
            n_cmp++;
            if (io_out !== e) begin n_bad++; $display("FAIL overflow step %0d io_out=%h want %h", i, io_out, e); end
         end
      end
   endtask

   task automatic test_underflow;
      logic [5:0] prog [$];
      logic [7:0] want [$];
      logic [7:0] e;
      // Start from a nonzero io_out so the OUT of a missing operand is visible.
      prog = '{CLR, pl(4'h9), OUT, CLR, alu(4'd0), OUT, STAT};
      want = '{8'h09, 8'h00, 8'h41};
      foreach (prog[i]) begin
         if (is_obs(prog[i])) sb.push_back(want.pop_front());
         exec(prog[i]);
         if (is_obs(prog[i])) begin
            e = sb.pop_front();
            n_cmp++;
            if (io_out !== e) begin n_bad++; $display("FAIL underflow step %0d io_out=%h want %h", i, io_out, e); end
         end
      end
   endtask

   task automatic test_wrap;
      logic [5:0] prog [$];
      logic [7:0] want [$];
      logic [7:0] e;
      prog = '{CLR, pl(4'h7), OUT, pl(4'hF), sh(4'hF), pl(4'h1), alu(4'd0), OUT,
               pl(4'h0), pl(4'h1), alu(4'd1), OUT};
      want = '{8'h07, 8'h00, 8'hFF};
      foreach (prog[i]) begin
         if (is_obs(prog[i])) sb.push_back(want.pop_front());
         exec(prog[i]);
         if (is_obs(prog[i])) begin
            e = sb.pop_front();
            n_cmp++;
            if (io_out !== e) begin n_bad++; $display("FAIL wrap step %0d io_out=%h want %h", i, io_out, e); end
         end
      end
   endtask

   // Exercises logic ops, unary ops, DUP, SWAP, DROP and the NOP encodings.
   task automatic test_logic;
      logic [5:0] prog [$];
      logic [7:0] want [$];
      logic [7:0] e;
      prog = '{CLR, pl(4'hC), sh(4'hA), alu(4'd5), pl(4'h5), sh(4'h3),
               alu(4'd2), OUT,           // AC & 35 = 24
               alu(4'd3), OUT,           // AC | 24 = AC
               alu(4'd8), OUT,           // ~AC = 53
               alu(4'd9), OUT,           // 53 << 1 = A6
               alu(4'd10), OUT,          // A6 >> 1 = 53
               pl(4'hF), alu(4'd4), OUT, // 53 ^ 0F = 5C
               pl(4'h1), alu(4'd7), OUT, // SWAP: top 5C
               alu(4'd6), OUT,           // DROP: top 01
               alu(4'd12), 6'b11_0101, STAT};
      want = '{8'h24, 8'hAC, 8'h53, 8'hA6, 8'h53, 8'h5C, 8'h5C, 8'h01, 8'h01};
      foreach (prog[i]) begin
         if (is_obs(prog[i])) sb.push_back(want.pop_front());
         exec(prog[i]);
         if (is_obs(prog[i])) begin
            e = sb.pop_front();
            n_cmp++;
            if (io_out !== e) begin n_bad++; $display("FAIL logic step %0d io_out=%h want %h", i, io_out, e); end
         end
      end
   endtask

   task automatic test_mul;
      logic [5:0] prog [$];
      logic [7:0] want [$];
      logic [7:0] e;
      prog = '{CLR, pl(4'h0), sh(4'h1), pl(4'h0), sh(4'h1), alu(4'd11), OUT,
               pl(4'h7), pl(4'h6), alu(4'd11), OUT, STAT};
`ifdef JLEIGHTCAP_MUL_EN
      want = '{8'h00, 8'h2A, 8'h02};
`else
      want = '{8'h10, 8'h06, 8'h04};
`endif
      foreach (prog[i]) begin
         if (is_obs(prog[i])) sb.push_back(want.pop_front());
         exec(prog[i]);
         if (is_obs(prog[i])) begin
            e = sb.pop_front();
            n_cmp++;
            if (io_out !== e) begin n_bad++; $display("FAIL mul step %0d io_out=%h want %h", i, io_out, e); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_arith;
      test_overflow;
      test_underflow;
      test_wrap;
      test_logic;
      test_mul;
      n_cmp++;
      if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain left=%0d want 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
